// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and defaults for the PWM compare stage.
//   - upd_state_e : duty-update handshake FSM states (IDLE, PENDING)
//   - db_state_e  : dead-time generator FSM states (OFF, DEAD, HI, LO)
//   - PWM_WIDTH_DEF / DEADBAND_DEF : default parameter values
//   - clamp_duty  : saturating limit helper for requested duty values
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_WIDTH_DEF = 4;
    localparam int DEADBAND_DEF  = 1;

    // Duty-update handshake states.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } upd_state_e;

    // Dead-time generator states.
    //   OFF  : post-reset, both outputs low
    //   DEAD : both outputs low while the dead counter runs
    //   HI   : high-side output on
    //   LO   : low-side (complementary) output on
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } db_state_e;

    // Saturate a requested duty at the full-period value.
    function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                               input logic [31:0] limit);
        logic [31:0] res;
        if (duty > limit) begin
            res = limit;
        end else begin
            res = duty;
        end
        return res;
    endfunction

endpackage : pwm_pkg

// File: rtl/deadband_gen.sv
// -----------------------------------------------------------------------------
// deadband_gen
// Turns a single raw PWM level into a complementary output pair with dead time.
// Every rising edge on either output is delayed by DEADBAND cycles after the
// raw level changes; falling edges leave with one cycle of latency. A raw pulse
// no longer than DEADBAND cycles never reaches its output because the dead
// counter restarts whenever the raw level flips while it is still counting.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   raw_i   in   raw PWM level (combinational compare result)
//   pwm_o   out  high-side output, registered
//   pwm_n_o out  low-side output, registered
// -----------------------------------------------------------------------------
module deadband_gen
    import pwm_pkg::*;
#(
    parameter int DEADBAND = DEADBAND_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic pwm_o,
    output logic pwm_n_o
);

    localparam logic [3:0] DEAD_CYCLES = 4'(DEADBAND);

    db_state_e  state_q, state_d;
    logic       tgt_q, tgt_d;      // side to switch on once dead time expires
    logic [3:0] cnt_q, cnt_d;      // dead cycles elapsed, starts at 1
    logic       pwm_q, pwm_n_q;

    // Next-state logic for the dead-time FSM.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                state_d = DEAD;
                tgt_d   = raw_i;
                cnt_d   = 4'd1;
            end
            DEAD: begin
                if (raw_i != tgt_q) begin
                    // Raw level flipped mid dead time: retarget and restart.
                    tgt_d = raw_i;
                    cnt_d = 4'd1;
                end else if (cnt_q >= DEAD_CYCLES) begin
                    state_d = tgt_q ? HI : LO;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (!raw_i) begin
                    state_d = DEAD;
                    tgt_d   = 1'b0;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = HI;
                end
            end
            LO: begin
                if (raw_i) begin
                    state_d = DEAD;
                    tgt_d   = 1'b1;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = LO;
                end
            end
            default: begin
                state_d = OFF;
                tgt_d   = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and registered output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
            tgt_q   <= 1'b0;
            cnt_q   <= 4'd0;
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            pwm_q   <= (state_d == HI);
            pwm_n_q <= (state_d == LO);
        end
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;

endmodule : deadband_gen

// File: rtl/pwm_compare.sv
// -----------------------------------------------------------------------------
// pwm_compare
// PWM stage fed by a free-running up counter. Compares the incoming count with
// the active duty every cycle and registers the result. New duty values are
// accepted over valid/ready into a shadow register and only become active at
// the period boundary, so a running period is never cut short or stretched.
//
// Optional feature macro: PWM_COMPLEMENT_EN
//   defined   -> pwm_n_out port exists; outputs pass through deadband_gen
//   undefined -> pwm_out is the registered raw compare, no dead-time logic
//
// Ports:
//   clk        in   rising-edge clock (same as the counter)
//   reset      in   synchronous active-high reset
//   count      in   WIDTH-bit counter value
//   duty_in    in   requested duty, WIDTH+1 bits, clamped to 2^WIDTH
//   duty_valid in   duty_in valid this cycle
//   duty_ready out  high while a new duty can be accepted
//   pwm_out    out  high-side PWM output, registered
//   pwm_n_out  out  complementary output (PWM_COMPLEMENT_EN only)
//   wrap       out  registered one-cycle pulse at each period boundary
// -----------------------------------------------------------------------------
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEF,
    parameter int DEADBAND = DEADBAND_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
`ifdef PWM_COMPLEMENT_EN
    output logic             pwm_n_out,
`endif
    output logic             wrap
);

    localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH:0]   DUTY_FULL  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   DUTY_ZERO  = {(WIDTH+1){1'b0}};

    // Reject dead-time settings the 4-bit dead counter cannot represent.
    if (DEADBAND < 1 || DEADBAND > 15) begin : g_deadband_range
        $error("pwm_compare: DEADBAND must be in 1..15");
    end

    upd_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_count_q;
    logic [WIDTH:0]   shadow_q, shadow_d;
    logic [WIDTH:0]   active_q, active_d;
    logic             ready_q;
    logic             wrap_q;

    logic             wrap_now_s;
    logic [WIDTH:0]   clamped_s;
    logic [WIDTH:0]   eff_s;
    logic             raw_s;

    // Only a step from the top value straight to zero is a period boundary;
    // other drops (e.g. upstream reset) must not trigger a duty swap.
    assign wrap_now_s = (prev_count_q == COUNT_MAX) && (count == COUNT_ZERO);

    assign clamped_s = (WIDTH+1)'(clamp_duty(32'(duty_in), 32'(DUTY_FULL)));

    // Duty-update FSM: accept into shadow, promote to active at wrap.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (duty_valid) begin
                    // An accept coinciding with wrap waits for the next wrap.
                    shadow_d = clamped_s;
                    state_d  = PENDING;
                end else begin
                    state_d  = IDLE;
                end
            end
            PENDING: begin
                if (wrap_now_s) begin
                    active_d = shadow_q;
                    state_d  = IDLE;
                end else begin
                    state_d  = PENDING;
                end
            end
            default: begin
                state_d  = IDLE;
                shadow_d = DUTY_ZERO;
                active_d = DUTY_ZERO;
            end
        endcase
    end

    // Effective duty: the promoted shadow already drives the wrap cycle.
    always_comb begin
        if ((state_q == PENDING) && wrap_now_s) begin
            eff_s = shadow_q;
        end else begin
            eff_s = active_q;
        end
    end

    // Zero-extended unsigned compare; duty 2^WIDTH keeps the output high.
    assign raw_s = ({1'b0, count} < eff_s);

    // Handshake state, duty registers, wrap detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= DUTY_ZERO;
            active_q     <= DUTY_ZERO;
            prev_count_q <= COUNT_ZERO;
            ready_q      <= 1'b1;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            prev_count_q <= count;
            ready_q      <= (state_d == IDLE);
            wrap_q       <= wrap_now_s;
        end
    end

    assign duty_ready = ready_q;
    assign wrap       = wrap_q;

`ifdef PWM_COMPLEMENT_EN
    deadband_gen #(
        .DEADBAND (DEADBAND)
    ) u_deadband_gen (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (raw_s),
        .pwm_o   (pwm_out),
        .pwm_n_o (pwm_n_out)
    );
`else
    logic pwm_q;

    // Registered raw compare output.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= raw_s;
        end
    end

    assign pwm_out = pwm_q;
`endif

endmodule : pwm_compare

// File: doc/pwm_compare.md
# pwm_compare

Downstream PWM stage for the free-running up counter. Consumes the counter's `counter` value and compares it each cycle against a duty value, producing a registered PWM output and a one-cycle wrap pulse. Duty updates arrive over a valid/ready handshake, are held in a shadow register, and take effect only at the period boundary (counter wrap), so no PWM period is ever glitched.

## Interface
- `WIDTH`, 4: width of the incoming count. Period = 2^WIDTH cycles.
- `DEADBAND`, 1: dead-time cycles, 1..15. Used only when `PWM_COMPLEMENT_EN` is defined.

- `clk`  in  1  rising-edge clock, same clock as the up counter
- `reset`  in  1  synchronous, active-high reset
- `count`  in  WIDTH  counter value from the upstream up counter
- `duty_in`  in  WIDTH+1  requested duty, 0..2^WIDTH high cycles per period
- `duty_valid`  in  1  duty_in is valid this cycle
- `duty_ready`  out  1  block can accept a new duty
- `pwm_out`  out  1  PWM output, high-side
- `pwm_n_out`  out  1  complementary output; present only with `PWM_COMPLEMENT_EN`
- `wrap`  out  1  one-cycle pulse, registered, marking a period boundary

## Operation
- Reset values:
  - `pwm_out`, `pwm_n_out`, `wrap` = 0
  - `duty_ready` = 1
  - active duty, shadow duty and `prev_count` = 0
  - update FSM state = IDLE
- Wrap detection:
  - `prev_count` registers `count` every cycle.
  - `wrap_now = (prev_count == 2^WIDTH-1) && (count == 0)`.
  - Any other decrease of `count`, such as an upstream reset, is not a wrap.
- Duty update FSM, two states:
  - **IDLE**: `duty_ready=1`. When `duty_valid` is high, load shadow ← min(`duty_in`, 2^WIDTH) (values above 2^WIDTH are clamped) and go to PENDING.
  - **PENDING**: `duty_ready=0`. `duty_valid` is ignored. On `wrap_now`, load active ← shadow and go to IDLE.
- Simultaneous `wrap_now` and an accept in IDLE: the duty is accepted, but it is applied at the following wrap, not the current one.
- Effective duty: `eff = (PENDING && wrap_now) ? shadow : active`.
- Compare: raw PWM = `count < eff`, compared unsigned with `count` zero-extended to WIDTH+1 bits.
  - duty 0 gives constant low.
  - duty 2^WIDTH gives constant high.
- Reset while PENDING discards the shadow value. Active duty returns to 0.

## Timing
- `pwm_out` is registered. It reflects the `count` sampled one cycle earlier: latency 1.
- `wrap` is asserted the cycle after the one in which `count` = 0 follows 2^WIDTH-1.
- A new duty affects the compare in the same cycle as `wrap_now`. The first affected `pwm_out` is therefore aligned with `wrap`.
- `duty_ready` falls the cycle after an accept. It rises the cycle after `wrap_now`.
- Steady state: `pwm_out` is high for exactly `duty` cycles out of every 2^WIDTH.

## Configuration
- `PWM_COMPLEMENT_EN` defined:
  - `pwm_n_out` exists and follows NOT raw PWM.
  - A dead-time stage delays every rising edge of `pwm_out` and of `pwm_n_out` by `DEADBAND` cycles. Falling edges pass with no extra delay.
  - `pwm_out` and `pwm_n_out` are never high in the same cycle.
  - A high pulse of `DEADBAND` cycles or shorter is suppressed entirely.
  - Total latency: falling edges 1 cycle, rising edges 1+`DEADBAND` cycles.
- `PWM_COMPLEMENT_EN` undefined:
  - No `pwm_n_out` port and no dead-time logic.
  - `pwm_out` = registered raw PWM.

## Structure
- Shared package `pwm_pkg`:
  - update FSM state enum `{IDLE, PENDING}`
  - default `WIDTH`
  - dead-time FSM state enum `{OFF, DEAD, HI, LO}`
- Sub-module `deadband_gen`: raw-PWM-to-complementary-pair generator with a dead counter. It is instantiated only under `PWM_COMPLEMENT_EN`.

## Test plan
- WIDTH=4, counter free-running. Accept duty 8 in the first period → from the first `wrap`, `pwm_out` is high 8 cycles and low 8 cycles every period.
- Duty 0 → `pwm_out` constant 0. Duty 16 → `pwm_out` constant 1. Duty 20 → clamped, behaves as 16.
- Active duty 4. Accept duty 12 at count 6 → `duty_ready` goes 0 the next cycle, the current period still runs 4 high cycles, the next period runs 12 high cycles, and `duty_ready` goes 1 the cycle after `wrap_now`.
- `duty_valid` pulsed exactly on the `wrap_now` cycle while IDLE → accepted, but applied one period later.
- `PWM_COMPLEMENT_EN`, DEADBAND=2, duty 8 → `pwm_out` is high 6 cycles and `pwm_n_out` is high 6 cycles per period, with 2 dead cycles at each edge and no overlap. Duty 2 → `pwm_out` never rises.
- Reset asserted while PENDING → after reset, `duty_ready=1`, active duty 0, `pwm_out` 0, and the discarded duty is never applied.
